// File: rtl/fp_add_pkg.sv
// Shared definitions for the single-precision add/sub post-adder stage:
// default field widths, bias, state encoding and flag bit positions.
package fp_add_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MANT_W = 24;
  localparam int BIAS       = 127;
  localparam int EXP_MAX    = (1 << DEF_EXP_W) - 1;

  // Normalise/round sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit positions inside out_flags = {overflow, underflow, zero}
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_OVF  = 2;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational rounding for a normalised mantissa: rounding increment,
// renormalise on carry-out, and pack the result (or infinity on overflow).
// Build option: FP_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the mantissa is truncated and guard/sticky are ignored.
module fp_round_unit
  import fp_add_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic                        i_sign,
  input  logic signed [EXP_W+1:0]     i_exp,
  input  logic        [MANT_W:0]      i_mant,
  input  logic                        i_guard,
  input  logic                        i_sticky,
  output logic        [EXP_W+MANT_W-1:0] o_result,
  output logic                        o_overflow
);

  localparam logic signed [EXP_W+1:0] L_EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] L_ONE     = (EXP_W+2)'(1);

  logic                    w_inc;
  logic [MANT_W:0]         w_sum;
  logic [MANT_W:0]         w_mant;
  logic signed [EXP_W+1:0] w_exp;
  logic [1:0]              w_unused_top;

`ifdef FP_ROUND_NEAREST_EN
  // Round half to even: bump when above half, or exactly half with odd LSB
  assign w_inc = i_guard & (i_sticky | i_mant[0]);
`else
  // Truncation never increments; guard/sticky are deliberately dropped
  logic w_unused_rnd;
  assign w_inc        = 1'b0;
  assign w_unused_rnd = i_guard ^ i_sticky;
`endif

  assign w_sum = i_mant + {{MANT_W{1'b0}}, w_inc};

  // Renormalise when the increment carried out of the hidden-bit position
  always_comb begin
    w_mant = w_sum;
    w_exp  = i_exp;
    if (w_sum[MANT_W]) begin
      w_mant = w_sum >> 1;
      w_exp  = i_exp + L_ONE;
    end
  end

  // Hidden bit and carry position are implied by the packed format
  assign w_unused_top = w_mant[MANT_W:MANT_W-1];

  // Saturate to infinity once the exponent reaches the all-ones code
  always_comb begin
    o_overflow = (w_exp >= L_EXP_MAX);
    if (o_overflow) begin
      o_result = {i_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
    end else begin
      o_result = {i_sign, w_exp[EXP_W-1:0], w_mant[MANT_W-2:0]};
    end
  end

endmodule

// File: rtl/fp_add_normalize_round.sv
// Post-adder stage of the single-precision add/sub datapath: latches the ALU
// magnitude, normalises one bit per cycle, rounds via fp_round_unit, and
// holds the packed result until the consumer accepts it.
// Build option: FP_ROUND_NEAREST_EN (round-to-nearest-even; default truncate).
module fp_add_normalize_round
  import fp_add_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MANT_W:0]             in_mant,
  input  logic                        in_sign,
  input  logic [EXP_W-1:0]            in_exp,
  input  logic                        in_guard,
  input  logic                        in_sticky,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+MANT_W-1:0]     out_result,
  output logic [2:0]                  out_flags
);

  localparam logic signed [EXP_W+1:0] L_ONE = (EXP_W+2)'(1);

  state_t                     r_state, w_state_next;
  logic [MANT_W:0]            r_mant, w_mant_next;
  logic                       r_sign, w_sign_next;
  logic signed [EXP_W+1:0]    r_exp, w_exp_next;
  logic                       r_guard, w_guard_next;
  logic                       r_sticky, w_sticky_next;
  logic [EXP_W+MANT_W-1:0]    r_result, w_result_next;
  logic [2:0]                 r_flags, w_flags_next;

  logic [EXP_W+MANT_W-1:0]    w_round_result;
  logic                       w_round_ovf;

  fp_round_unit #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W)
  ) u_round (
    .i_sign     (r_sign),
    .i_exp      (r_exp),
    .i_mant     (r_mant),
    .i_guard    (r_guard),
    .i_sticky   (r_sticky),
    .o_result   (w_round_result),
    .o_overflow (w_round_ovf)
  );

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_flags  = r_flags;

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and datapath updates; NORM checks are strictly prioritised
  always_comb begin
    w_state_next  = r_state;
    w_mant_next   = r_mant;
    w_sign_next   = r_sign;
    w_exp_next    = r_exp;
    w_guard_next  = r_guard;
    w_sticky_next = r_sticky;
    w_result_next = r_result;
    w_flags_next  = r_flags;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_mant_next   = in_mant;
          w_sign_next   = in_sign;
          w_exp_next    = {2'b00, in_exp};
          w_guard_next  = in_guard;
          w_sticky_next = in_sticky;
          w_state_next  = ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_mant == '0) begin
          // Exact cancellation always yields +0
          w_result_next           = '0;
          w_flags_next            = '0;
          w_flags_next[FLAG_ZERO] = 1'b1;
          w_state_next            = ST_DONE;
        end else if (r_mant[MANT_W]) begin
          // Carry out of the ALU: one right shift restores normal form
          w_mant_next   = r_mant >> 1;
          w_exp_next    = r_exp + L_ONE;
          w_guard_next  = r_mant[0];
          w_sticky_next = r_guard | r_sticky;
          w_state_next  = ST_ROUND;
        end else if (r_mant[MANT_W-1]) begin
          w_state_next = ST_ROUND;
        end else if (r_exp == L_ONE) begin
          // No denormal support: flush to a signed zero
          w_result_next          = {r_sign, {(EXP_W+MANT_W-1){1'b0}}};
          w_flags_next           = '0;
          w_flags_next[FLAG_UNF] = 1'b1;
          w_state_next           = ST_DONE;
        end else begin
          w_mant_next  = {r_mant[MANT_W-1:0], r_guard};
          w_guard_next = 1'b0;
          w_exp_next   = r_exp - L_ONE;
        end
      end
      ST_ROUND: begin
        w_result_next          = w_round_result;
        w_flags_next           = '0;
        w_flags_next[FLAG_OVF] = w_round_ovf;
        w_state_next           = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand, working and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant   <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_mant   <= w_mant_next;
      r_sign   <= w_sign_next;
      r_exp    <= w_exp_next;
      r_guard  <= w_guard_next;
      r_sticky <= w_sticky_next;
      r_result <= w_result_next;
      r_flags  <= w_flags_next;
    end
  end

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Randomised self-checking bench for fp_add_normalize_round with a
// plain-arithmetic reference model, directed corner cases and handshake checks.
module tb_fp_add_normalize_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_mant;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_guard;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int n_total = 0;
  int n_bad   = 0;

  fp_add_normalize_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_guard   (in_guard),
    .in_sticky  (in_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: normalise, round and pack using integer arithmetic
  task automatic ref_model(input logic [24:0] mant, input logic sign, input logic [7:0] exp,
                           input logic g_in, input logic s_in,
                           output logic [31:0] res, output logic [2:0] fl, output int lat);
    int m, e, g, s, k, inc;
    m = int'(mant); e = int'(exp); g = int'(g_in); s = int'(s_in); k = 0;
    res = 32'h0; fl = 3'b000;
    if (m == 0) begin
      fl = 3'b001; lat = 2;
      return;
    end
    if (m >= (1 << 24)) begin
      s = g | s; g = m & 1; m = m >> 1; e = e + 1;
    end else begin
      while (m < (1 << 23)) begin
        if (e == 1) begin
          res = {sign, 31'h0}; fl = 3'b010; lat = k + 2;
          return;
        end
        m = m * 2 + g; g = 0; e = e - 1; k++;
      end
    end
    lat = k + 3;
`ifdef FP_ROUND_NEAREST_EN
    inc = g & (s | (m & 1));
`else
    inc = 0;
`endif
    m = m + inc;
    if (m >= (1 << 24)) begin
      m = m >> 1; e = e + 1;
    end
    if (e >= 255) begin
      res = {sign, 8'hFF, 23'h0}; fl = 3'b100;
    end else begin
      res = {sign, 8'(e), 23'(m)};
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One full transaction: accept, wait for result, optional backpressure, drain
  task automatic do_op(input logic [24:0] mant, input logic sign, input logic [7:0] exp,
                       input logic g, input logic s, input int hold, output logic [31:0] obs);
    logic [31:0] e_res;
    logic [2:0]  e_fl;
    int          e_lat;
    int          cyc;
    ref_model(mant, sign, exp, g, s, e_res, e_fl, e_lat);
    in_mant = mant; in_sign = sign; in_exp = exp; in_guard = g; in_sticky = s;
    in_valid = 1'b1; out_ready = 1'b0;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    obs = out_result;
    check_eq("out_valid_seen", 32'(out_valid), 32'd1);
    if (!out_valid) begin
      pulse_reset();
      return;
    end
    check_eq("latency", 32'(cyc), 32'(e_lat));
    check_eq("result", out_result, e_res);
    check_eq("flags", 32'(out_flags), 32'(e_fl));
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_result", out_result, e_res);
      check_eq("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    check_eq("drain_ready", 32'(in_ready), 32'd1);
    $display("op mant=%h sign=%b exp=%h g=%b s=%b -> result=%h flags=%b lat=%0d",
             mant, sign, exp, g, s, obs, out_flags, cyc);
  endtask

  initial begin
    logic [31:0] obs;
    logic [24:0] rm;
    int          seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_sign = 1'b0; in_exp = '0; in_guard = 1'b0; in_sticky = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_result", out_result, 32'h0);
    check_eq("rst_flags", 32'(out_flags), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed corner cases with known encodings
    do_op(25'h0800000, 1'b0, 8'h7F, 1'b0, 1'b0, 0, obs);
    check_eq("t1_one", obs, 32'h3F800000);
    do_op(25'h1000000, 1'b0, 8'h7F, 1'b0, 1'b0, 1, obs);
    check_eq("t2_carry", obs, 32'h40000000);
    do_op(25'h0000001, 1'b0, 8'h7F, 1'b0, 1'b0, 0, obs);
    check_eq("t3_k23", obs, 32'h34000000);
    do_op(25'h0000000, 1'b1, 8'h7F, 1'b0, 1'b0, 0, obs);
    check_eq("t4_zero", obs, 32'h00000000);
    do_op(25'h0400000, 1'b1, 8'h01, 1'b0, 1'b0, 0, obs);
    check_eq("t4_underflow", obs, 32'h80000000);
    do_op(25'h0FFFFFF, 1'b0, 8'h7F, 1'b1, 1'b1, 0, obs);
`ifdef FP_ROUND_NEAREST_EN
    check_eq("t5_round", obs, 32'h40000000);
`else
    check_eq("t5_round", obs, 32'h3FFFFFFF);
`endif
    do_op(25'h1000000, 1'b0, 8'hFE, 1'b0, 1'b0, 5, obs);
    check_eq("t6_overflow", obs, 32'h7F800000);

    // Reset while normalising abandons the operation
    in_mant = 25'h0000001; in_sign = 1'b0; in_exp = 8'h7F; in_guard = 1'b0; in_sticky = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_result", out_result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_eq("abandoned", 32'(seen), 32'd0);
    $display("op reset-in-NORM abandon seen_valid=%0d", seen);

    // Randomised operations over the whole shift range
    for (int i = 0; i < 250; i++) begin
      rm = 25'($urandom) >> $urandom_range(0, 25);
      do_op(rm, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3), obs);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
